enc_stage_sequencer: RTL and testbench
======================================

# enc_stage_sequencer

Top-level round sequencer for the encoder datapath. It drives the per-stage start/Ready/Done handshake of each permutation stage (column parity first, then the remaining stages in order) for every round, and pulses a memory swap between stages. It sits above the stage controllers and below the encoder top. It detects handshake violations and stalls, and aborts on them.

## Interface
- NUM_STAGES, 5, number of stage controllers; stage 0 is column parity
- NUM_ROUNDS, 24, rounds per encode
- TIMEOUT, 4095, maximum WAIT cycles per stage before abort
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  begin an encode; sampled only in IDLE
- stage_ready  input  NUM_STAGES  Ready of each stage controller; high only while that stage is idle
- stage_done  input  NUM_STAGES  Done of each stage; may pulse many times per run (e.g. once per slice); informational only
- ready  output  1  high in IDLE
- done  output  1  one-cycle pulse when all rounds are complete
- stage_start  output  NUM_STAGES  one-hot one-cycle start pulse to the current stage
- mem_swap  output  1  one-cycle pulse that swaps the ping-pong state memory after each stage
- round  output  5  current round index, 0..NUM_ROUNDS-1
- stage  output  3  current stage index, 0..NUM_STAGES-1
- done_cnt  output  7  stage_done pulses counted for the current stage, saturating at 127
- err  output  1  sticky error flag; cleared only by reset or by an accepted start

## Operation
- Moore FSM with states IDLE, ISSUE, ARM, WAIT, SWAP, FINISH. All outputs decode from state and registers only.
- IDLE: ready=1. When start=1: clear round, stage, done_cnt and err, then go to ISSUE.
- ISSUE: if stage_ready[stage]=1, drive stage_start[stage]=1 and go to ARM. Otherwise hold in ISSUE with stage_start=0 until the stage is ready.
- ARM: one cycle. stage_ready[stage] must be 0 here, because the stage has left its idle state.
  - If it is 0, go to WAIT.
  - If it is 1, the start was not accepted: set err and go to IDLE.
- WAIT: the watchdog counts cycles.
  - Each cycle with stage_done[stage]=1 increments done_cnt.
  - When stage_ready[stage]=1, the stage is complete: go to SWAP.
  - If the watchdog reaches TIMEOUT, set err and go to IDLE.
  - stage_done or stage_ready of any other stage toggling is ignored.
- SWAP: mem_swap=1 for one cycle. Then:
  - If stage<NUM_STAGES-1: stage+1, clear done_cnt, go to ISSUE.
  - Else if round<NUM_ROUNDS-1: round+1, stage=0, clear done_cnt, go to ISSUE.
  - Else go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE. round, stage and done_cnt hold their last values until the next start.
- start outside IDLE is ignored.
- The watchdog is a 12-bit counter, cleared on entry to WAIT.
- round and stage never wrap past their maxima.

## Timing
- Reset values: ps=IDLE, ready=1, done=0, stage_start=0, mem_swap=0, round=0, stage=0, done_cnt=0, err=0.
- Accepting start at edge k puts the FSM in ISSUE during cycle k+1, with stage_start[0]=1 if stage 0 is ready. The FSM is in ARM during cycle k+2 and in WAIT from cycle k+3.
- Per-stage overhead is 3 cycles (ISSUE, ARM, SWAP) plus the WAIT length. The WAIT length is the stage latency measured from ARM to the first cycle stage_ready is high again.
- A stage whose ready rises in WAIT cycle w gets mem_swap in cycle w+1 and its successor's stage_start in cycle w+2.
- The final SWAP is followed by done in the next cycle, then ready=1 in the cycle after that.
- If stage_done and stage_ready for the current stage are both high in the same WAIT cycle, the pulse is counted and the stage completes.
- Asynchronous reset mid-run returns the FSM to IDLE immediately, with all outputs at their reset values. No mem_swap or done is emitted.

## Test plan
- Model every stage as: ready drops 1 cycle after start, 10 cycles busy with stage_done pulsing 4 times, then ready returns. Pulse start. Required: 120 stage_start pulses in order 0,1,2,3,4 per round; 120 mem_swap pulses; done exactly once after round=23, stage=4; done_cnt=4 before each swap; err=0.
- Hold stage_ready[2]=0 for 20 cycles when stage 2 is due. Required: the FSM holds in ISSUE with no stage_start; stage_start[2] appears in the first cycle ready is high.
- A stage ignores start (ready stays 1 in ARM). Required: err=1 and IDLE the next cycle; no mem_swap.
- A stage never returns ready. Required: err=1 after 4095 WAIT cycles, then IDLE with ready=1.
- Pulse start again during WAIT, and toggle another stage's done/ready. Required: no effect on the sequence or on done_cnt.
- Assert reset during round 7, stage 3, WAIT. Required: all outputs at reset values the same cycle; a fresh start then runs a full 24 rounds correctly.

Source files
------------

// File: rtl/enc_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : enc_stage_sequencer
//  Purpose  : Round sequencer for the encoder datapath. Issues a one-hot start
//             to each permutation stage in turn, waits for it to finish, pulses
//             the ping-pong memory swap, and repeats for every round. Aborts
//             with a sticky error if a stage rejects its start or stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module enc_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_ROUNDS = 24,
  parameter int TIMEOUT    = 4095
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic                  o_mem_swap,
  output logic [4:0]            o_round,
  output logic [2:0]            o_stage,
  output logic [6:0]            o_done_cnt,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_SWAP   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [4:0]            c_LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [2:0]            c_LAST_STAGE = 3'(NUM_STAGES - 1);
  // Abort happens in the WAIT cycle where the count shows TIMEOUT-1, so the
  // stage gets exactly TIMEOUT WAIT cycles in total.
  localparam logic [11:0]           c_WDOG_LAST  = 12'(TIMEOUT - 1);
  localparam logic [6:0]            c_CNT_MAX    = 7'd127;
  localparam logic [NUM_STAGES-1:0] c_ONE        = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_mem_swap;
  logic                  r_err;
  logic [4:0]            r_round;
  logic [2:0]            r_stage;
  logic [6:0]            r_done_cnt;
  logic [11:0]           r_wdog;

  logic                  w_cur_ready;
  logic                  w_cur_done;
  logic [NUM_STAGES-1:0] w_onehot;

  // Handshake lines of the stage currently being sequenced; others are ignored.
  assign w_cur_ready = i_stage_ready[r_stage];
  assign w_cur_done  = i_stage_done[r_stage];
  assign w_onehot    = c_ONE << r_stage;

  // Start is offered only while ISSUE sees the current stage idle, so it lands
  // in the very first cycle that stage reports ready.
  assign o_stage_start = ((r_state == S_ISSUE) && w_cur_ready) ? w_onehot : '0;

  assign o_ready    = r_ready;
  assign o_done     = r_done;
  assign o_mem_swap = r_mem_swap;
  assign o_round    = r_round;
  assign o_stage    = r_stage;
  assign o_done_cnt = r_done_cnt;
  assign o_err      = r_err;

  // Sequencer FSM; single-cycle flag outputs are set on the transition into
  // the state that presents them, so they are registered and glitch free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_mem_swap <= 1'b0;
      r_err      <= 1'b0;
      r_round    <= 5'd0;
      r_stage    <= 3'd0;
      r_done_cnt <= 7'd0;
      r_wdog     <= 12'd0;
    end else begin
      r_done     <= 1'b0;
      r_mem_swap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_round    <= 5'd0;
            r_stage    <= 3'd0;
            r_done_cnt <= 7'd0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_cur_ready) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          // A stage that accepted its start must have left idle by now.
          if (w_cur_ready) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wdog  <= 12'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_cur_done && (r_done_cnt != c_CNT_MAX)) begin
            r_done_cnt <= r_done_cnt + 7'd1;
          end
          if (w_cur_ready) begin
            r_mem_swap <= 1'b1;
            r_state    <= S_SWAP;
          end else if (r_wdog == c_WDOG_LAST) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 12'd1;
          end
        end
        S_SWAP: begin
          if (r_stage != c_LAST_STAGE) begin
            r_stage    <= r_stage + 3'd1;
            r_done_cnt <= 7'd0;
            r_state    <= S_ISSUE;
          end else if (r_round != c_LAST_ROUND) begin
            r_round    <= r_round + 5'd1;
            r_stage    <= 3'd0;
            r_done_cnt <= 7'd0;
            r_state    <= S_ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enc_stage_sequencer
//  Purpose  : Directed bench for enc_stage_sequencer with a behavioural model
//             of the stage controllers and hand-computed cycle expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enc_stage_sequencer;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tb_start = 1'b0;
  logic [NS-1:0] tb_stage_ready;
  logic [NS-1:0] tb_stage_done;
  logic          o_ready, o_done, o_mem_swap, o_err;
  logic [NS-1:0] o_stage_start;
  logic [4:0]    o_round;
  logic [2:0]    o_stage;
  logic [6:0]    o_done_cnt;

  int checks = 0;
  int failures = 0;

  enc_stage_sequencer #(.NUM_STAGES(NS), .NUM_ROUNDS(24), .TIMEOUT(4095)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (tb_start),
    .i_stage_ready (tb_stage_ready),
    .i_stage_done  (tb_stage_done),
    .o_ready       (o_ready),
    .o_done        (o_done),
    .o_stage_start (o_stage_start),
    .o_mem_swap    (o_mem_swap),
    .o_round       (o_round),
    .o_stage       (o_stage),
    .o_done_cnt    (o_done_cnt),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  // Stage controller model: ready drops the cycle after start, 10 busy cycles,
  // done pulses on busy cycles 2,4,6,8, then ready returns.
  int            m_cnt [NS];
  logic [NS-1:0] m_rdy;
  logic [NS-1:0] m_done;
  logic [NS-1:0] hold_low = '0;
  logic [NS-1:0] ignore_start = '0;
  logic [NS-1:0] hang = '0;
  logic [NS-1:0] tog_rdy = '0;
  logic [NS-1:0] tog_done = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) m_cnt[i] <= 0;
      m_rdy <= '1;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_cnt[i] == 0) begin
          if (m_rdy[i] && o_stage_start[i] && !ignore_start[i]) begin
            m_rdy[i] <= 1'b0;
            m_cnt[i] <= 10;
          end
        end else if (m_cnt[i] == 1) begin
          if (!hang[i]) begin
            m_cnt[i] <= 0;
            m_rdy[i] <= 1'b1;
          end
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  always_comb begin
    m_done = '0;
    for (int i = 0; i < NS; i++)
      m_done[i] = (m_cnt[i] == 8) || (m_cnt[i] == 6) || (m_cnt[i] == 4) || (m_cnt[i] == 2);
  end

  assign tb_stage_ready = (m_rdy & ~hold_low) ^ tog_rdy;
  assign tb_stage_done  = m_done | tog_done;

  // Pulse monitor: counts starts/swaps/dones and flags out-of-order starts.
  int n_start = 0, n_swap = 0, n_done = 0, n_order_err = 0, n_dcnt_bad = 0;
  int mon_seq = 0;
  logic [NS-1:0] mon_exp;
  always @(negedge clk) begin
    if (reset) begin
      mon_seq = 0;
    end else begin
      if (o_stage_start != '0) begin
        n_start++;
        mon_exp = NS'(1) << mon_seq;
        if (o_stage_start !== mon_exp) n_order_err++;
        mon_seq = (mon_seq == NS - 1) ? 0 : mon_seq + 1;
      end
      if (o_mem_swap) begin
        n_swap++;
        if (o_done_cnt !== 7'd4) n_dcnt_bad++;
      end
      if (o_done) n_done++;
    end
  end

  logic [23:0] w_pack;
  assign w_pack = {o_ready, o_done, o_stage_start, o_mem_swap, o_round, o_stage, o_done_cnt, o_err};
  localparam logic [23:0] c_RESET_PACK = 24'h800000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, bad;
  int s_start, s_swap, s_done, s_order, s_dcnt;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(w_pack), 32'(c_RESET_PACK));
    reset = 1'b0;
    tick();
    check("idle_after_reset", 32'(w_pack), 32'(c_RESET_PACK));

    // ---------------- ISSUE hold on stage 2, then reset mid-run ----------------
    hold_low = 5'b00100;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    check("first_start", 32'(o_stage_start), 32'h1);
    check("ready_low_in_run", 32'(o_ready), 32'h0);
    n = 0;
    while (o_stage !== 3'd2 && n < 200) begin tick(); n++; end
    check("cycles_to_stage2", n, 26);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_stage_start !== '0) bad++;
      tick();
    end
    check("issue_hold_no_start", bad, 0);
    hold_low = '0;
    #1;
    check("start2_on_ready", 32'(o_stage_start), 32'h4);
    n = 0;
    while (!(o_round == 5'd7 && o_stage == 3'd3) && n < 2000) begin tick(); n++; end
    check("reach_r7_s3", 32'({o_round, o_stage}), 32'({5'd7, 3'd3}));
    repeat (5) tick();
    check("dcnt_mid_wait", 32'(o_done_cnt), 32'd1);
    check("dcnt_before_swaps", n_dcnt_bad, 0);
    s_swap = n_swap;
    s_done = n_done;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(w_pack), 32'(c_RESET_PACK));
    repeat (2) tick();
    check("no_pulse_in_reset", (n_swap - s_swap) + (n_done - s_done), 0);
    reset = 1'b0;
    tick();

    // ---------------- full 24-round run with disturbances ----------------
    s_start = n_start; s_swap = n_swap; s_done = n_done;
    s_order = n_order_err; s_dcnt = n_dcnt_bad;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    n = 1;
    repeat (4) begin tick(); n++; end
    tb_start = 1'b1;
    tog_rdy  = 5'b00010;
    tog_done = 5'b11110;
    repeat (3) begin tick(); n++; end
    tb_start = 1'b0;
    tog_rdy  = '0;
    tog_done = '0;
    while (!o_done && n < 3000) begin tick(); n++; end
    check("run_latency", n, 1561);
    check("done_round_stage", 32'({o_round, o_stage}), 32'({5'd23, 3'd4}));
    check("run_err", 32'(o_err), 32'h0);
    check("start_pulses", n_start - s_start, 120);
    check("start_order", n_order_err - s_order, 0);
    check("swap_pulses", n_swap - s_swap, 120);
    check("dcnt_at_swap", n_dcnt_bad - s_dcnt, 0);
    tick();
    check("ready_after_done", 32'({o_ready, o_done}), 32'h2);
    check("done_once", n_done - s_done, 1);
    check("hold_after_done", 32'({o_round, o_stage, o_done_cnt}), 32'({5'd23, 3'd4, 7'd4}));

    // ---------------- stage ignores start ----------------
    ignore_start = 5'b00001;
    s_swap = n_swap;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    check("ign_start_issued", 32'(o_stage_start), 32'h1);
    tick();
    check("ign_arm", 32'({o_err, o_ready}), 32'h0);
    tick();
    check("ign_abort", 32'({o_err, o_ready}), 32'h3);
    check("ign_no_swap", n_swap - s_swap, 0);
    ignore_start = '0;

    // ---------------- stage never returns ready ----------------
    hang = 5'b00001;
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    check("err_cleared_on_start", 32'(o_err), 32'h0);
    repeat (4096) tick();
    check("wdog_last_wait", 32'({o_err, o_ready}), 32'h0);
    check("wdog_dcnt", 32'(o_done_cnt), 32'd4);
    tick();
    check("wdog_abort", 32'({o_err, o_ready}), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
